// File: rtl/comp_double256_pkg.sv
// Shared widths and the sum-width helper for the two-column weighted compressor.
package comp_double256_pkg;

  localparam int N_BITS = 256;
  localparam int OUT_W  = 10;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int sum_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : comp_double256_pkg

// File: rtl/comp_double256_popcount_tree.sv
// Combinational population counter. It is built as a balanced binary tree of
// pairwise adders. Each tree level lives in its own generate block. Every node
// carries the full result width, so no carry can be dropped at any level. Leaves
// past WIDTH are tied to zero so that the tree can be padded to a power of two.
module comp_double256_popcount_tree
  import comp_double256_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0]            i_bits,
  output logic [sum_width(WIDTH)-1:0] o_count
);

  localparam int SW     = sum_width(WIDTH);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int LEAVES = 1 << LEVELS;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      logic [SW-1:0] w_node [LEAVES >> gi];
      if (gi == 0) begin : g_leaf
        // Level 0: each input bit is zero-extended to the full count width.
        for (gj = 0; gj < LEAVES; gj++) begin : g_bit
          if (gj < WIDTH) begin : g_real
            assign w_node[gj] = SW'(i_bits[gj]);
          end else begin : g_pad
            assign w_node[gj] = '0;
          end
        end
      end else begin : g_add
        // Each node is the sum of two neighbouring nodes from the previous level.
        for (gj = 0; gj < (LEAVES >> gi); gj++) begin : g_pair
          assign w_node[gj] = g_lvl[gi-1].w_node[2*gj] + g_lvl[gi-1].w_node[2*gj+1];
        end
      end
    end
  endgenerate

  assign o_count = g_lvl[LEVELS].w_node[0];

endmodule : comp_double256_popcount_tree

// File: rtl/comp_double256.sv
// Two-column weighted compressor. It computes
// comp_out = popcount(in_col0) + 2*popcount(in_col1).
// The result is registered once: one cycle of latency and one new vector per cycle.
module comp_double256
  import comp_double256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] in_col0,
  input  logic [N_BITS-1:0] in_col1,
  output logic [OUT_W-1:0]  comp_out
);

  localparam int CW = sum_width(N_BITS);

  logic [CW-1:0]    w_cnt0;
  logic [CW-1:0]    w_cnt1;
  logic [OUT_W-1:0] w_sum;
  logic [OUT_W-1:0] r_comp_out;

  comp_double256_popcount_tree #(.WIDTH(N_BITS)) u_tree_col0 (
    .i_bits  (in_col0),
    .o_count (w_cnt0)
  );

  comp_double256_popcount_tree #(.WIDTH(N_BITS)) u_tree_col1 (
    .i_bits  (in_col1),
    .o_count (w_cnt1)
  );

  // Column 1 carries weight 2. Both counts are widened before the shift and the add,
  // so the maximum of 768 fits without truncation.
  assign w_sum = OUT_W'(w_cnt0) + (OUT_W'(w_cnt1) << 1);

  // Output register. Reset clears it at once and discards any result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp_out <= '0;
    end else begin
      r_comp_out <= w_sum;
    end
  end

  assign comp_out = r_comp_out;

endmodule : comp_double256

// File: tb/tb_comp_double256.sv
// Directed and streaming checks for comp_double256.
module tb_comp_double256;

  logic         clk;
  logic         rst_n;
  logic [255:0] in_col0;
  logic [255:0] in_col1;
  logic [9:0]   comp_out;

  int n_pass;
  int n_total;

  comp_double256 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_col0  (in_col0),
    .in_col1  (in_col1),
    .comp_out (comp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector at the falling edge. Let the rising edge sample it, then look 1 ns later.
  task automatic apply_and_wait(input logic [255:0] c0, input logic [255:0] c1);
    @(negedge clk);
    in_col0 = c0;
    in_col1 = c1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [255:0] ones;
    ones = '1;
    rst_n = 1'b0;
    // Drive all ones while reset is held, so a clocked-in value would show up.
    in_col0 = ones;
    in_col1 = ones;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (comp_out !== 10'd0) $display("FAIL reset_hold[%0d]: got %0d expected 0", i, comp_out);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_col0 = '0;
    in_col1 = '0;
    @(posedge clk);
    #1;
    n_total++;
    if (comp_out !== 10'h000) $display("FAIL reset_first_edge: got %0d expected 0", comp_out);
    else n_pass++;
  endtask

  task automatic test_corners;
    logic [255:0] ones;
    logic [255:0] zero;
    logic [255:0] msb;
    logic [255:0] lsb;
    ones = '1;
    zero = '0;
    msb = '0;
    msb[255] = 1'b1;
    lsb = '0;
    lsb[0] = 1'b1;
    apply_and_wait(ones, zero);
    n_total++;
    if (comp_out !== 10'h100) $display("FAIL corner_c0_ones: got %0d expected 256", comp_out);
    else n_pass++;
    apply_and_wait(zero, ones);
    n_total++;
    if (comp_out !== 10'h200) $display("FAIL corner_c1_ones: got %0d expected 512", comp_out);
    else n_pass++;
    apply_and_wait(ones, ones);
    n_total++;
    if (comp_out !== 10'h300) $display("FAIL corner_both_ones: got %0d expected 768", comp_out);
    else n_pass++;
    apply_and_wait(msb, lsb);
    n_total++;
    if (comp_out !== 10'd3) $display("FAIL single_msb_lsb: got %0d expected 3", comp_out);
    else n_pass++;
  endtask

  task automatic test_walk;
    logic [255:0] v;
    logic [255:0] zero;
    zero = '0;
    for (int i = 0; i < 256; i++) begin
      v = '0;
      v[i] = 1'b1;
      apply_and_wait(v, zero);
      n_total++;
      if (comp_out !== 10'd1) $display("FAIL walk_c0[%0d]: got %0d expected 1", i, comp_out);
      else n_pass++;
    end
    for (int i = 0; i < 256; i++) begin
      v = '0;
      v[i] = 1'b1;
      apply_and_wait(zero, v);
      n_total++;
      if (comp_out !== 10'd2) $display("FAIL walk_c1[%0d]: got %0d expected 2", i, comp_out);
      else n_pass++;
    end
  endtask

  task automatic test_alternating;
    logic [255:0] a;
    logic [255:0] b;
    a = {64{4'hA}};
    b = {64{4'h5}};
    apply_and_wait(a, b);
    n_total++;
    if (comp_out !== 10'h180) $display("FAIL alternating_a5: got %0d expected 384", comp_out);
    else n_pass++;
    apply_and_wait(b, a);
    n_total++;
    if (comp_out !== 10'h180) $display("FAIL alternating_5a: got %0d expected 384", comp_out);
    else n_pass++;
  endtask

  // Random vector with varied density, so that sums near 0 and near 768 both occur.
  task automatic rand_vec(output logic [255:0] v);
    logic [255:0] m;
    int mode;
    for (int w = 0; w < 8; w++) begin
      v[w*32 +: 32] = $urandom;
      m[w*32 +: 32] = $urandom;
    end
    mode = $urandom_range(0, 3);
    if (mode == 1) v = v & m;
    else if (mode == 2) v = v | m;
  endtask

  task automatic test_back_to_back(input int n_vec);
    logic [255:0] c0;
    logic [255:0] c1;
    logic [9:0]   exp_prev;
    bit           have_prev;
    have_prev = 1'b0;
    exp_prev = '0;
    for (int k = 0; k <= n_vec; k++) begin
      @(negedge clk);
      if (have_prev) begin
        n_total++;
        if (comp_out !== exp_prev)
          $display("FAIL stream[%0d]: got %0d expected %0d", k - 1, comp_out, exp_prev);
        else n_pass++;
      end
      if (k < n_vec) begin
        rand_vec(c0);
        rand_vec(c1);
        in_col0 = c0;
        in_col1 = c1;
        exp_prev = 10'($countones(c0)) + 10'(2 * $countones(c1));
        have_prev = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset;
    logic [255:0] ones;
    logic [255:0] zero;
    logic [255:0] v;
    ones = '1;
    zero = '0;
    apply_and_wait(ones, ones);
    n_total++;
    if (comp_out !== 10'h300) $display("FAIL pre_async_value: got %0d expected 768", comp_out);
    else n_pass++;
    // Assert reset between edges. The output must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (comp_out !== 10'd0) $display("FAIL async_clear: got %0d expected 0", comp_out);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (comp_out !== 10'd0) $display("FAIL async_hold_edge: got %0d expected 0", comp_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    v = {64{4'h3}};
    in_col0 = v;
    in_col1 = zero;
    @(posedge clk);
    #1;
    n_total++;
    if (comp_out !== 10'd128) $display("FAIL async_resume: got %0d expected 128", comp_out);
    else n_pass++;
    apply_and_wait(zero, ones);
    n_total++;
    if (comp_out !== 10'h200) $display("FAIL async_resume_next: got %0d expected 512", comp_out);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    in_col0 = '0;
    in_col1 = '0;
    test_reset();
    test_corners();
    test_walk();
    test_alternating();
    test_back_to_back(20000);
    test_async_reset();
    test_back_to_back(200);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_comp_double256
